// File: rtl/pipeline_hazard_unit.sv
// Pipeline hazard sequencer: load-use stalls, branch-mispredict flushes and interrupt injection.
// Outputs are decoded from the current state and live inputs; reset forces every output low.
module pipeline_hazard_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_x_addr,
    input  logic [4:0] id_y_addr,
    input  logic       id_uses_x,
    input  logic       id_uses_y,
    input  logic [4:0] ex_wb_addr,
    input  logic       ex_rf_wr,
    input  logic       ex_mem_rd,
    input  logic       ex_br_valid,
    input  logic       ex_br_taken,
    input  logic       ex_br_pred,
    input  logic       int_req,
    input  logic       int_en,
    output logic       pc_stall,
    output logic       ifid_stall,
    output logic       ifid_flush,
    output logic       idex_nop,
    output logic       redirect,
    output logic       inject_int,
    output logic       int_ack,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        StRun     = 3'd0,
        StLuStall = 3'd1,
        StFlush   = 3'd2,
        StIntWait = 3'd3,
        StIntInj  = 3'd4,
        StIntMask = 3'd5
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] mask_cnt_q, mask_cnt_d;
    logic       hazard;
    logic       mispredict;

    assign hazard = ex_mem_rd & ex_rf_wr &
                    ((id_uses_x & (id_x_addr == ex_wb_addr)) |
                     (id_uses_y & (id_y_addr == ex_wb_addr)));

    assign mispredict = ex_br_valid & (ex_br_taken != ex_br_pred);

    assign state = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StRun;
            mask_cnt_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            mask_cnt_q <= mask_cnt_d;
        end
    end

    always_comb begin
        state_d    = StRun;
        mask_cnt_d = 2'd0;
        case (state_q)
            StRun: begin
                if (mispredict) begin
                    state_d = StFlush;
                end else if (hazard) begin
                    state_d = StLuStall;
                end else if (int_req && int_en) begin
                    state_d = ex_br_valid ? StIntWait : StIntInj;
                end
            end
            StLuStall: state_d = StRun;
            StFlush:   state_d = StRun;
            StIntWait: begin
                // A mispredicted branch squashes the pending interrupt.
                if (mispredict) begin
                    state_d = StFlush;
                end else if (ex_br_valid) begin
                    state_d = StIntWait;
                end else begin
                    state_d = StIntInj;
                end
            end
            StIntInj: begin
                state_d    = StIntMask;
                mask_cnt_d = 2'd2;
            end
            StIntMask: begin
                if (mispredict) begin
                    state_d = StFlush;
                end else if (hazard) begin
                    state_d = StLuStall;
                end else if (mask_cnt_q > 2'd1) begin
                    state_d    = StIntMask;
                    mask_cnt_d = mask_cnt_q - 2'd1;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        pc_stall   = 1'b0;
        ifid_stall = 1'b0;
        ifid_flush = 1'b0;
        idex_nop   = 1'b0;
        redirect   = 1'b0;
        inject_int = 1'b0;
        int_ack    = 1'b0;
        if (!rst) begin
            case (state_q)
                StRun, StIntMask: begin
                    if (mispredict) begin
                        redirect   = 1'b1;
                        ifid_flush = 1'b1;
                        idex_nop   = 1'b1;
                    end else if (hazard) begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        idex_nop   = 1'b1;
                    end
                end
                StLuStall: begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    idex_nop   = 1'b1;
                end
                StFlush: begin
                    ifid_flush = 1'b1;
                    idex_nop   = 1'b1;
                end
                StIntWait: begin
                    // PC must be free to load the redirect target.
                    if (mispredict) begin
                        redirect   = 1'b1;
                        ifid_flush = 1'b1;
                        idex_nop   = 1'b1;
                    end else begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                    end
                end
                StIntInj: begin
                    inject_int = 1'b1;
                    int_ack    = 1'b1;
                    pc_stall   = 1'b1;
                    ifid_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
